cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arb_pkg.sv | 15 +
 rtl/eight_bit_comparator.sv | 16 +
 rtl/cmp_arbiter.sv | 146 ++++++++++++++
 tb/tb_cmp_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the compare arbiter.
package cmp_arb_pkg;

    localparam int unsigned OP_WIDTH = 8;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator; exactly one output is high.
module eight_bit_comparator
    import cmp_arb_pkg::*;
(
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
    output logic                AgB,
    output logic                BgA,
    output logic                AeB
);

    assign AgB = (a > b);
    assign BgA = (b > a);
    assign AeB = (a == b);

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of a shared 8-bit comparator.
// Optional feature: define CMP_ARB_STATS_EN to add the eq_cnt output, a saturating
// count of accepted results that reported A==B.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [OP_WIDTH-1:0] a0,
    input  logic [OP_WIDTH-1:0] b0,
    input  logic [OP_WIDTH-1:0] a1,
    input  logic [OP_WIDTH-1:0] b1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rsp_valid,
    output req_id_t             rsp_id,
    output logic                rsp_agb,
    output logic                rsp_bga,
    output logic                rsp_aeb,
    input  logic                rsp_ready
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [OP_WIDTH-1:0] eq_cnt
`endif
);

    state_e              r_state;
    state_e              w_state_next;
    req_id_t             r_prio;
    logic [OP_WIDTH-1:0] r_op_a;
    logic [OP_WIDTH-1:0] r_op_b;
    req_id_t             r_op_id;
    req_id_t             r_rsp_id;
    logic                r_agb;
    logic                r_bga;
    logic                r_aeb;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic                w_agb;
    logic                w_bga;
    logic                w_aeb;

    // Grant selection (only in IDLE, priority pointer first) and next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_prio == 1'b0) begin
                    if (req0)      w_gnt0 = 1'b1;
                    else if (req1) w_gnt1 = 1'b1;
                end else begin
                    if (req1)      w_gnt1 = 1'b1;
                    else if (req0) w_gnt0 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) w_state_next = CMP;
            end
            CMP:     w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == RESP) && rsp_ready;

    // FSM state and priority pointer; priority flips away from the owner of each accepted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prio  <= (FIRST_PRIO != 0);
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_prio <= ~r_op_id;
        end
    end

    // Operand capture on the granting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_id <= 1'b0;
        end else if (w_gnt0) begin
            r_op_a  <= a0;
            r_op_b  <= b0;
            r_op_id <= 1'b0;
        end else if (w_gnt1) begin
            r_op_a  <= a1;
            r_op_b  <= b1;
            r_op_id <= 1'b1;
        end
    end

    eight_bit_comparator u_cmp (
        .a   (r_op_a),
        .b   (r_op_b),
        .AgB (w_agb),
        .BgA (w_bga),
        .AeB (w_aeb)
    );

    // Result register loaded during the single CMP cycle, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id <= 1'b0;
            r_agb    <= 1'b0;
            r_bga    <= 1'b0;
            r_aeb    <= 1'b0;
        end else if (r_state == CMP) begin
            r_rsp_id <= r_op_id;
            r_agb    <= w_agb;
            r_bga    <= w_bga;
            r_aeb    <= w_aeb;
        end
    end

`ifdef CMP_ARB_STATS_EN
    logic [OP_WIDTH-1:0] r_eq_cnt;

    // Saturating count of accepted equal results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_cnt <= '0;
        end else if (w_accept && r_aeb && (r_eq_cnt != '1)) begin
            r_eq_cnt <= r_eq_cnt + 1'b1;
        end
    end

    assign eq_cnt = r_eq_cnt;
`endif

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_agb   = r_agb;
    assign rsp_bga   = r_bga;
    assign rsp_aeb   = r_aeb;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: a transaction-level model predicts grants, pushes the
// expected result at each grant, and a negedge monitor pops and compares on acceptance.
module tb_cmp_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       rsp_valid;
    logic       rsp_id;
    logic       rsp_agb, rsp_bga, rsp_aeb;
    logic       rsp_ready;
`ifdef CMP_ARB_STATS_EN
    logic [7:0] eq_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    cmp_arbiter #(.FIRST_PRIO(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_agb   (rsp_agb),
        .rsp_bga   (rsp_bga),
        .rsp_aeb   (rsp_aeb),
        .rsp_ready (rsp_ready)
`ifdef CMP_ARB_STATS_EN
        ,
        .eq_cnt    (eq_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    typedef struct {
        logic id;
        logic agb;
        logic bga;
        logic aeb;
    } exp_t;

    exp_t q[$];
    logic log_ids[$];
    bit   m_busy = 0;
    int   m_age  = 0;
    logic m_prio = 1'b0;
    int   m_eq   = 0;

    always @(negedge clk) begin
        exp_t e;
        logic g0, g1;
        if (!rst_n) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_id", rsp_id, 0);
            chk("rst_flags", {rsp_agb, rsp_bga, rsp_aeb}, 0);
`ifdef CMP_ARB_STATS_EN
            chk("rst_eq_cnt", eq_cnt, 0);
`endif
            q.delete();
            m_busy = 0;
            m_age  = 0;
            m_prio = 1'b0;
            m_eq   = 0;
        end else begin
`ifdef CMP_ARB_STATS_EN
            chk("eq_cnt", eq_cnt, m_eq);
`endif
            if (!m_busy) begin
                // Priority requester wins if requesting, else the other one.
                g0 = 1'b0;
                g1 = 1'b0;
                if (m_prio == 1'b0) begin
                    if (req0) g0 = 1'b1; else if (req1) g1 = 1'b1;
                end else begin
                    if (req1) g1 = 1'b1; else if (req0) g0 = 1'b1;
                end
                chk("gnt0", gnt0, g0);
                chk("gnt1", gnt1, g1);
                chk("idle_valid", rsp_valid, 0);
                if (g0 || g1) begin
                    e.id  = g1;
                    e.agb = g1 ? (a1 > b1) : (a0 > b0);
                    e.bga = g1 ? (b1 > a1) : (b0 > a0);
                    e.aeb = g1 ? (a1 == b1) : (a0 == b0);
                    q.push_back(e);
                    m_busy = 1;
                    m_age  = 0;
                end
            end else begin
                m_age++;
                chk("busy_gnt", {gnt0, gnt1}, 0);
                if (m_age == 1) begin
                    chk("cmp_valid", rsp_valid, 0);
                end else begin
                    e = q[0];
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_flags", {rsp_agb, rsp_bga, rsp_aeb}, {e.agb, e.bga, e.aeb});
                    chk("onehot", $countones({rsp_agb, rsp_bga, rsp_aeb}), 1);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        log_ids.push_back(rsp_id);
                        m_prio = ~e.id;
                        if (e.aeb && m_eq < 255) m_eq++;
                        m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from requester id, held for exactly one cycle from an idle block.
    task automatic single(input logic id, input logic [7:0] a, input logic [7:0] b);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        logic [7:0] bnd_a[5];
        logic [7:0] bnd_b[5];
        rst_n = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        rsp_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Contention from reset: expect id0, id1, id0.
        rsp_ready = 1'b1;
        log_ids.delete();
        req0 = 1; a0 = 8'hC0; b0 = 8'h01;
        req1 = 1; a1 = 8'h7F; b1 = 8'h7F;
        repeat (8) step();
        req0 = 0; req1 = 0;
        repeat (3) step();
        chk("cont_count", log_ids.size(), 3);
        if (log_ids.size() == 3) begin
            chk("cont_id0", log_ids[0], 0);
            chk("cont_id1", log_ids[1], 1);
            chk("cont_id2", log_ids[2], 0);
        end

        // Single request.
        single(1'b0, 8'h01, 8'h80);

        // Backpressure with another requester pending.
        rsp_ready = 1'b0;
        req1 = 1; a1 = 8'h33; b1 = 8'h44;
        step();
        req1 = 0;
        req0 = 1; a0 = 8'h10; b0 = 8'h0F;
        repeat (7) step();
        rsp_ready = 1'b1;
        step();
        req0 = 0;
        repeat (4) step();

        // Boundary operand pairs.
        bnd_a = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80};
        bnd_b = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h7F};
        for (int i = 0; i < 5; i++) single(i[0], bnd_a[i], bnd_b[i]);

        // Reset while in CMP, then a fresh request.
        req0 = 1; a0 = 8'h55; b0 = 8'hAA;
        step();
        req0 = 0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        single(1'b1, 8'h02, 8'h01);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            a0 = $urandom_range(0, 255);
            a1 = $urandom_range(0, 255);
            b0 = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom_range(0, 255));
            b1 = ($urandom_range(0, 3) == 0) ? a1 : 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req0 = 0; req1 = 0; rsp_ready = 1'b1;
        repeat (4) step();

        // Long run of equal pairs to saturate the equality counter.
        req0 = 1; a0 = 8'h5A; b0 = 8'h5A;
        req1 = 1; a1 = 8'hFF; b1 = 8'hFF;
        repeat (930) step();
        req0 = 0; req1 = 0;
        repeat (4) step();
`ifdef CMP_ARB_STATS_EN
        chk("eq_cnt_sat", eq_cnt, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
